// File: rtl/ifm_loader.sv
// ifm_loader: sequences a sparse IFM stream (sparsemap + nonzero bytes) into chunk memory writes
// Ports: clk_i/rst_i clock and sync reset; start_i/chunk_base_i/chunk_num_i load command;
// busy_o/done_o/err_o/chunk_loaded_o status; s_* input stream; wr_* chunk memory write port.
module ifm_loader #(
  parameter int CHUNK_SIZE = 128,
  parameter int BUS_SIZE = 32,
  parameter int IFM_NUM = 6,
  localparam int DAT_CYC_NUM = CHUNK_SIZE / BUS_SIZE,
  localparam int CW = $clog2(IFM_NUM),
  localparam int DW = $clog2(DAT_CYC_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [CW-1:0]         chunk_base_i,
  input  logic [CW:0]           chunk_num_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [IFM_NUM-1:0]    chunk_loaded_o,
  input  logic [BUS_SIZE-1:0]   s_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0] s_nonzero_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  wr_valid_o,
  output logic [DW-1:0]         wr_dat_count_o,
  output logic [CW-1:0]         wr_chunk_count_o
);
  localparam logic [CW:0] IFM_W = (CW+1)'(IFM_NUM);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(IFM_NUM - 1);
  localparam logic [DW-1:0] LAST_DAT = DW'(DAT_CYC_NUM - 1);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nxt;
  logic [DW-1:0] dat_cnt;
  logic [CW-1:0] chunk_cnt;
  logic [CW:0] remaining;
  logic bad, go, acc, chunk_end, last;
  assign bad = ({1'b0, chunk_base_i} >= IFM_W) || (chunk_num_i > IFM_W);
  assign go = start_i && state == IDLE && !bad && chunk_num_i != '0;
  assign s_ready_o = state == LOAD;
  assign busy_o = state != IDLE;
  assign acc = s_valid_i && s_ready_o;
  assign chunk_end = dat_cnt == LAST_DAT;
  assign last = acc && chunk_end && remaining == (CW+1)'(1);
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (go ? LOAD : IDLE) :
                state == LOAD ? (last ? DONE : LOAD) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_cnt <= '0;
      chunk_cnt <= '0;
      remaining <= '0;
      chunk_loaded_o <= '0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_sparsemap_o <= '0;
      wr_nonzero_data_o <= '0;
      wr_dat_count_o <= '0;
      wr_chunk_count_o <= '0;
    end else begin
      wr_valid_o <= acc;
      done_o <= last || (start_i && state == IDLE && !bad && chunk_num_i == '0);
      err_o <= start_i && state == IDLE && bad;
      if (acc) begin
        wr_sparsemap_o <= s_sparsemap_i;
        wr_nonzero_data_o <= s_nonzero_data_i;
        wr_dat_count_o <= dat_cnt;
        wr_chunk_count_o <= chunk_cnt;
        dat_cnt <= chunk_end ? '0 : dat_cnt + 1'b1;
        if (chunk_end) begin
          chunk_cnt <= chunk_cnt == LAST_CHUNK ? '0 : chunk_cnt + 1'b1;
          remaining <= remaining - 1'b1;
          chunk_loaded_o[chunk_cnt] <= 1'b1;
        end
      end
      if (go) begin
        dat_cnt <= '0;
        chunk_cnt <= chunk_base_i;
        remaining <= chunk_num_i;
        chunk_loaded_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ifm_loader.sv
// tb_ifm_loader: randomized and directed check of ifm_loader against a queue-based write model
module tb_ifm_loader;
  logic clk_i, rst_i, start_i;
  logic [2:0] chunk_base_i;
  logic [3:0] chunk_num_i;
  logic busy_o, done_o, err_o;
  logic [5:0] chunk_loaded_o;
  logic [31:0] s_sparsemap_i;
  logic [255:0] s_nonzero_data_i;
  logic s_valid_i, s_ready_o;
  logic [31:0] wr_sparsemap_o;
  logic [255:0] wr_nonzero_data_o;
  logic wr_valid_o;
  logic [1:0] wr_dat_count_o;
  logic [2:0] wr_chunk_count_o;
  int total = 0, bad = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int vprob = 0;
  bit tog = 0;
  int qc[$], qd[$];
  bit m_in_done = 0, m_done = 0, m_err = 0, m_wv = 0;
  logic [5:0] m_loaded = '0;
  logic [31:0] m_sm = '0;
  logic [255:0] m_nz = '0;
  int m_dat = 0, m_chunk = 0;
  ifm_loader #(.CHUNK_SIZE(128), .BUS_SIZE(32), .IFM_NUM(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .chunk_base_i(chunk_base_i),
    .chunk_num_i(chunk_num_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .chunk_loaded_o(chunk_loaded_o), .s_sparsemap_i(s_sparsemap_i),
    .s_nonzero_data_i(s_nonzero_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .wr_sparsemap_o(wr_sparsemap_o), .wr_nonzero_data_o(wr_nonzero_data_o),
    .wr_valid_o(wr_valid_o), .wr_dat_count_o(wr_dat_count_o), .wr_chunk_count_o(wr_chunk_count_o)
  );
  initial clk_i = 0;
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk_i) begin
    s_sparsemap_i = $urandom;
    for (int i = 0; i < 8; i++) s_nonzero_data_i[i*32 +: 32] = $urandom;
    s_valid_i = tog ? !s_valid_i : ($urandom_range(99) < vprob);
  end
  // model: a load is a queue of (chunk slot, beat) pairs consumed one per valid beat
  always @(posedge clk_i) begin
    if (rst_i) begin
      qc.delete(); qd.delete();
      m_in_done = 0; m_done = 0; m_err = 0; m_wv = 0;
      m_loaded = '0; m_sm = '0; m_nz = '0; m_dat = 0; m_chunk = 0;
    end else begin
      m_done = 0; m_err = 0; m_wv = 0;
      if (qc.size() > 0) begin
        if (s_valid_i) begin
          m_wv = 1; m_sm = s_sparsemap_i; m_nz = s_nonzero_data_i;
          m_chunk = qc.pop_front(); m_dat = qd.pop_front();
          if (m_dat == 3) m_loaded[m_chunk] = 1'b1;
          if (qc.size() == 0) begin m_done = 1; m_in_done = 1; end
        end
      end else if (m_in_done) m_in_done = 0;
      else if (start_i) begin
        if (chunk_base_i >= 6 || chunk_num_i > 6) m_err = 1;
        else if (chunk_num_i == 0) m_done = 1;
        else begin
          m_loaded = '0;
          for (int k = 0; k < int'(chunk_num_i); k++)
            for (int d = 0; d < 4; d++) begin qc.push_back((int'(chunk_base_i) + k) % 6); qd.push_back(d); end
        end
      end
    end
    #1;
    chk("ready", s_ready_o, qc.size() > 0);
    chk("busy", busy_o, qc.size() > 0 || m_in_done);
    chk("done", done_o, m_done);
    chk("err", err_o, m_err);
    chk("wr_valid", wr_valid_o, m_wv);
    chk("loaded", chunk_loaded_o, m_loaded);
    chk("wr_sparsemap", wr_sparsemap_o, m_sm);
    chk("wr_nonzero", wr_nonzero_data_o, m_nz);
    chk("wr_dat", wr_dat_count_o, 256'(m_dat));
    chk("wr_chunk", wr_chunk_count_o, 256'(m_chunk));
    if (wr_valid_o) wr_cnt++;
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
  end
  task automatic cmd(input int base, input int num);
    @(negedge clk_i);
    start_i = 1; chunk_base_i = 3'(base); chunk_num_i = 4'(num);
    @(negedge clk_i);
    start_i = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((qc.size() > 0 || m_in_done) && n < 1000) begin @(negedge clk_i); n++; end
    if (n >= 1000) begin bad++; total++; $display("FAIL wait_idle timeout act=busy exp=idle"); end
  endtask
  int w0, d0, e0;
  initial begin
    rst_i = 1; start_i = 0; chunk_base_i = 0; chunk_num_i = 0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", s_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_wr_valid", wr_valid_o, 0);
    chk("rst_loaded", chunk_loaded_o, 0);
    rst_i = 0;
    vprob = 100; w0 = wr_cnt; d0 = done_cnt;
    cmd(0, 2); wait_idle();
    chk("t2_writes", wr_cnt - w0, 8);
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_loaded", chunk_loaded_o, 6'b000011);
    tog = 1; w0 = wr_cnt;
    cmd(0, 2); wait_idle();
    tog = 0;
    chk("t3_writes", wr_cnt - w0, 8);
    chk("t3_loaded", chunk_loaded_o, 6'b000011);
    vprob = 100;
    cmd(5, 2); wait_idle();
    chk("t4_loaded", chunk_loaded_o, 6'b100001);
    vprob = 0; w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    cmd(0, 0);
    chk("t5_zero_done", done_cnt - d0, 1);
    cmd(0, 7);
    cmd(6, 1);
    @(negedge clk_i);
    chk("t5_errs", err_cnt - e0, 2);
    chk("t5_no_writes", wr_cnt - w0, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_loaded_kept", chunk_loaded_o, 6'b100001);
    vprob = 50;
    cmd(1, 1); cmd(3, 2); wait_idle();
    chk("t5_ignored", chunk_loaded_o, 6'b000010);
    vprob = 100;
    cmd(2, 1);
    repeat (3) @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    chk("t6_wr_valid", wr_valid_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_loaded", chunk_loaded_o, 0);
    w0 = wr_cnt;
    cmd(2, 1); wait_idle();
    chk("t6_writes", wr_cnt - w0, 4);
    chk("t6_reload", chunk_loaded_o, 6'b000100);
    repeat (40) begin
      vprob = $urandom_range(100, 20);
      cmd($urandom_range(7), $urandom_range(8));
      if ($urandom_range(4) == 0) cmd($urandom_range(5), $urandom_range(6, 1));
      if ($urandom_range(9) == 0) begin
        repeat ($urandom_range(6)) @(negedge clk_i);
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
      end
      wait_idle();
    end
    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
